// File: rtl/cpu_pkg.sv
// Shared constants for the ALU/PC datapath slice.
package cpu_pkg;

  // Default data width of the PC, ALU operands and shared bus.
  localparam int WIDTH_DEF = 8;

  // Program-counter value forced while reset is asserted.
  localparam int unsigned PC_RESET_VAL = 0;

endpackage

// File: rtl/alu_pc_datapath_if.sv
// Signal bundle between the datapath and whatever controls it.
// The controller holds the master modport. The datapath holds the slave modport.
interface alu_pc_datapath_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             ce;
  logic             j;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             co;
  logic             eo;

  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] bus_out;
  logic             bus_oe;
  logic             bus_conflict;

  modport master (
    output ce, j, bus_in, a, b, cin, co, eo,
    input  pc_out, sum, cout, bus_out, bus_oe, bus_conflict
  );

  modport slave (
    input  ce, j, bus_in, a, b, cin, co, eo,
    output pc_out, sum, cout, bus_out, bus_oe, bus_conflict
  );

endinterface

// File: rtl/pc_counter.sv
// Program counter with the following behaviour:
//   - A jump loads the counter from the bus, and a jump takes priority over counting.
//   - When counting, the value wraps with no overflow flag.
//   - An active-low async reset clears the counter.
module pc_counter
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_i,
  input  logic             j_i,
  input  logic [WIDTH-1:0] load_i,
  output logic [WIDTH-1:0] pc_o
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Next PC: the jump has priority, then the increment, otherwise the PC holds.
  always_comb begin
    pc_d = pc_q;
    if (j_i) begin
      pc_d = load_i;
    end else if (ce_i) begin
      pc_d = pc_q + WIDTH'(1);
    end
  end

  // PC register. Reset clears the register at once. While reset is held, the jump and ce inputs are masked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= WIDTH'(PC_RESET_VAL);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/alu_pc_datapath.sv
// Datapath top: it contains the PC register, a combinational adder and the driver for the shared bus.
// The ALU and the bus mux have no state, so they ignore reset.
module alu_pc_datapath
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_pc_datapath_if.slave      dp
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH:0]   alu_full;

  pc_counter #(.WIDTH(WIDTH)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .ce_i   (dp.ce),
    .j_i    (dp.j),
    .load_i (dp.bus_in),
    .pc_o   (pc_q)
  );

  // The adder is one bit wider than the data, so the overflow lands only in cout.
  always_comb begin
    alu_full = {1'b0, dp.a} + {1'b0, dp.b} + {{WIDTH{1'b0}}, dp.cin};
    dp.sum   = alu_full[WIDTH-1:0];
    dp.cout  = alu_full[WIDTH];
  end

  // Bus driver: when both enables are set, the ALU result wins and the conflict flag is raised.
  always_comb begin
    dp.pc_out       = pc_q;
    dp.bus_oe       = dp.eo | dp.co;
    dp.bus_conflict = dp.eo & dp.co;
    if (dp.eo) begin
      dp.bus_out = alu_full[WIDTH-1:0];
    end else if (dp.co) begin
      dp.bus_out = pc_q;
    end else begin
      dp.bus_out = '0;
    end
  end

endmodule

// File: tb/tb_alu_pc_datapath.sv
module tb_alu_pc_datapath;
  import cpu_pkg::*;

  localparam int W = WIDTH_DEF;
  localparam int MOD = 1 << W;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   pc_m;

  alu_pc_datapath_if #(.WIDTH(W)) dp_if ();

  alu_pc_datapath #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ce, input int j, input int bus_in, input int a,
                       input int b, input int cin, input int co, input int eo);
    dp_if.ce     = ce[0];
    dp_if.j      = j[0];
    dp_if.bus_in = bus_in[W-1:0];
    dp_if.a      = a[W-1:0];
    dp_if.b      = b[W-1:0];
    dp_if.cin    = cin[0];
    dp_if.co     = co[0];
    dp_if.eo     = eo[0];
  endtask

  // The outputs follow directly from the arithmetic rules and the current model PC.
  task automatic check_comb(input string tag);
    int s, es, ec, eb;
    s  = int'(dp_if.a) + int'(dp_if.b) + int'(dp_if.cin);
    es = s % MOD;
    ec = s / MOD;
    eb = dp_if.eo ? es : (dp_if.co ? pc_m : 0);
    check({tag, ".sum"},  32'(dp_if.sum), 32'(es));
    check({tag, ".cout"}, 32'(dp_if.cout), 32'(ec));
    check({tag, ".bus"},  32'(dp_if.bus_out), 32'(eb));
    check({tag, ".oe"},   32'(dp_if.bus_oe), 32'(dp_if.eo | dp_if.co));
    check({tag, ".cfl"},  32'(dp_if.bus_conflict), 32'(dp_if.eo & dp_if.co));
  endtask

  // One clock edge. The model advances from the inputs applied at the edge.
  task automatic step(input string tag);
    int nxt;
    if (!reset)          nxt = 0;
    else if (dp_if.j)    nxt = int'(dp_if.bus_in);
    else if (dp_if.ce)   nxt = (pc_m + 1) % MOD;
    else                 nxt = pc_m;
    @(posedge clk);
    #1;
    pc_m = nxt;
    check({tag, ".pc"}, 32'(dp_if.pc_out), 32'(pc_m));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pc_m  = 0;
    reset = 1'b0;
    drive(1, 1, 8'hAA, 0, 0, 0, 0, 0);
    #1;
    check("rst_pc", 32'(dp_if.pc_out), 32'h0);
    step("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_release_pc", 32'(dp_if.pc_out), 32'h0);

    // The jump loads 0x05, and then reset is asserted between clock edges.
    @(negedge clk);
    drive(0, 1, 8'h05, 0, 0, 0, 0, 0);
    step("load05");
    #2;
    reset = 1'b0;
    drive(1, 1, 8'h77, 0, 0, 0, 0, 0);
    #1;
    pc_m = 0;
    check("rst_mid_immediate", 32'(dp_if.pc_out), 32'h0);
    step("rst_mid_edge1");
    step("rst_mid_edge2");
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_mid_release", 32'(dp_if.pc_out), 32'h0);
    step("first_count");

    // Count from 0xFE and wrap.
    @(negedge clk);
    drive(0, 1, 8'hFE, 0, 0, 0, 0, 0);
    step("load_fe");
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("wrap_ff");
    check("wrap_ff_const", 32'(dp_if.pc_out), 32'hFF);
    step("wrap_00");
    check("wrap_00_const", 32'(dp_if.pc_out), 32'h00);
    step("wrap_01");
    check("wrap_01_const", 32'(dp_if.pc_out), 32'h01);

    // When j and ce are both high, the jump wins.
    @(negedge clk);
    drive(1, 1, 8'h3C, 0, 0, 0, 0, 0);
    step("jump_prio");
    check("jump_prio_const", 32'(dp_if.pc_out), 32'h3C);

    // The PC holds when both j and ce are low.
    @(negedge clk);
    drive(0, 0, 8'h11, 0, 0, 0, 0, 0);
    step("hold");
    check("hold_const", 32'(dp_if.pc_out), 32'h3C);

    // Directed ALU vectors.
    @(negedge clk);
    drive(0, 0, 0, 8'hF0, 8'h20, 1, 0, 0);
    #1;
    check("alu1_sum", 32'(dp_if.sum), 32'h11);
    check("alu1_cout", 32'(dp_if.cout), 32'h1);
    drive(0, 0, 0, 8'h03, 8'h04, 0, 0, 0);
    #1;
    check("alu2_sum", 32'(dp_if.sum), 32'h07);
    check("alu2_cout", 32'(dp_if.cout), 32'h0);
    drive(0, 0, 0, 8'hFF, 8'hFF, 1, 0, 0);
    #1;
    check("alu_max_sum", 32'(dp_if.sum), 32'hFF);
    check("alu_max_cout", 32'(dp_if.cout), 32'h1);

    // Directed bus-mux cases with the PC loaded to 0x09.
    @(negedge clk);
    drive(0, 1, 8'h09, 0, 0, 0, 0, 0);
    step("load09");
    @(negedge clk);
    drive(0, 0, 0, 8'h03, 8'h04, 0, 1, 0);
    #1;
    check("mux_pc_bus", 32'(dp_if.bus_out), 32'h09);
    check("mux_pc_oe", 32'(dp_if.bus_oe), 32'h1);
    check("mux_pc_cfl", 32'(dp_if.bus_conflict), 32'h0);
    drive(0, 0, 0, 8'h03, 8'h04, 0, 1, 1);
    #1;
    check("mux_both_bus", 32'(dp_if.bus_out), 32'h07);
    check("mux_both_cfl", 32'(dp_if.bus_conflict), 32'h1);
    check("mux_both_oe", 32'(dp_if.bus_oe), 32'h1);
    drive(0, 0, 0, 8'h03, 8'h04, 0, 0, 1);
    #1;
    check("mux_alu_bus", 32'(dp_if.bus_out), 32'h07);
    drive(0, 0, 0, 8'h03, 8'h04, 0, 0, 0);
    #1;
    check("mux_none_bus", 32'(dp_if.bus_out), 32'h00);
    check("mux_none_oe", 32'(dp_if.bus_oe), 32'h0);

    // Randomized traffic, with j kept rare so that the counter runs for long stretches.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7) == 0),
            int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
            int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      #1;
      check_comb("rand");
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
